// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive and transmit engines.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } uart_state_t;

    // Count at which the receiver resamples the start bit, i.e. mid-bit.
    function automatic int half_bit_count(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rxd.sv
// 8N1 serial receiver: 2-flop input synchronizer followed by a mid-bit sampling FSM.
module uart_rxd
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_Serial,
    output logic       rx_DV_out,
    output logic [7:0] rx_Byte_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit_count(CLKS_PER_BIT));

    logic              r_rx_meta;
    logic              r_rx_sync;
    uart_state_t       r_state;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_rx_byte;
    logic              r_rx_dv;

    uart_state_t       w_state_nxt;
    logic [CNT_W-1:0]  w_clk_cnt_nxt;
    logic [2:0]        w_bit_idx_nxt;
    logic [7:0]        w_rx_byte_nxt;
    logic              w_rx_dv_nxt;

    // Synchronizer resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_Serial;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_rx_byte <= '0;
            r_rx_dv   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_rx_byte <= w_rx_byte_nxt;
            r_rx_dv   <= w_rx_dv_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_rx_byte_nxt = r_rx_byte;
        w_rx_dv_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                w_clk_cnt_nxt = '0;
                w_bit_idx_nxt = '0;
                if (!r_rx_sync) begin
                    w_state_nxt = START;
                end
            end

            // A line that is high again at mid-bit was only a glitch.
            START: begin
                if (r_clk_cnt == HALF_CNT) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = r_rx_sync ? IDLE : DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (r_clk_cnt == LAST_CNT) begin
                    w_clk_cnt_nxt            = '0;
                    w_rx_byte_nxt[r_bit_idx] = r_rx_sync;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end

            // A low stop bit is a framing error: the byte stays but no DV is raised.
            STOP: begin
                if (r_clk_cnt == LAST_CNT) begin
                    w_clk_cnt_nxt = '0;
                    w_rx_dv_nxt   = r_rx_sync;
                    w_state_nxt   = CLEANUP;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end

            CLEANUP: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rx_DV_out   = r_rx_dv;
    assign rx_Byte_out = r_rx_byte;

endmodule

// File: rtl/uart_txd.sv
// 8N1 serial transmitter: latches a byte on request and shifts it out LSB first.
module uart_txd
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_DV,
    input  logic [7:0] tx_Byte,
    output logic       tx_Active_out,
    output logic       tx_Serial_out,
    output logic       tx_Done_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t       r_state;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_tx_data;
    logic              r_tx_serial;
    logic              r_tx_active;
    logic              r_tx_done;

    uart_state_t       w_state_nxt;
    logic [CNT_W-1:0]  w_clk_cnt_nxt;
    logic [2:0]        w_bit_idx_nxt;
    logic [7:0]        w_tx_data_nxt;
    logic              w_tx_serial_nxt;
    logic              w_tx_active_nxt;
    logic              w_tx_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_tx_data   <= '0;
            r_tx_serial <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_cnt   <= w_clk_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_serial <= w_tx_serial_nxt;
            r_tx_active <= w_tx_active_nxt;
            r_tx_done   <= w_tx_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clk_cnt_nxt   = r_clk_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_tx_data_nxt   = r_tx_data;
        w_tx_active_nxt = r_tx_active;
        w_tx_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                w_clk_cnt_nxt = '0;
                w_bit_idx_nxt = '0;
                if (tx_DV) begin
                    w_tx_data_nxt   = tx_Byte;
                    w_tx_active_nxt = 1'b1;
                    w_state_nxt     = START;
                end
            end

            START: begin
                if (r_clk_cnt == LAST_CNT) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (r_clk_cnt == LAST_CNT) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (r_clk_cnt == LAST_CNT) begin
                    w_clk_cnt_nxt   = '0;
                    w_tx_active_nxt = 1'b0;
                    w_tx_done_nxt   = 1'b1;
                    w_state_nxt     = CLEANUP;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end

            CLEANUP: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level is registered from the next state so the start bit appears the cycle after acceptance.
    always_comb begin
        w_tx_serial_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_tx_serial_nxt = 1'b0;
            DATA:    w_tx_serial_nxt = w_tx_data_nxt[w_bit_idx_nxt];
            default: w_tx_serial_nxt = 1'b1;
        endcase
    end

    assign tx_Active_out = r_tx_active;
    assign tx_Serial_out = r_tx_serial;
    assign tx_Done_out   = r_tx_done;

endmodule

// File: rtl/uart_rxd_txd.sv
// Full-duplex 8N1 UART: independent receiver and transmitter sharing one clock and reset.
module uart_rxd_txd
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_Serial,
    output logic       rx_DV_out,
    output logic [7:0] rx_Byte_out,
    input  logic       tx_DV,
    input  logic [7:0] tx_Byte,
    output logic       tx_Active_out,
    output logic       tx_Serial_out,
    output logic       tx_Done_out
);

    uart_rxd #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rxd (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_Serial   (rx_Serial),
        .rx_DV_out   (rx_DV_out),
        .rx_Byte_out (rx_Byte_out)
    );

    uart_txd #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_txd (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_DV         (tx_DV),
        .tx_Byte       (tx_Byte),
        .tx_Active_out (tx_Active_out),
        .tx_Serial_out (tx_Serial_out),
        .tx_Done_out   (tx_Done_out)
    );

endmodule

// File: tb/tb_uart_rxd_txd.sv
// Directed and randomized bench for uart_rxd_txd at 115200 baud on a 25 MHz clock.
`timescale 1ns/1ps
module tb_uart_rxd_txd;

    localparam int CPB    = 217;
    localparam int CLK_NS = 40;
    localparam int BIT_NS = CPB * CLK_NS;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       rx_Serial = 1'b1;
    logic       tx_DV     = 1'b0;
    logic [7:0] tx_Byte   = 8'h00;
    logic       rx_DV_out;
    logic [7:0] rx_Byte_out;
    logic       tx_Active_out;
    logic       tx_Serial_out;
    logic       tx_Done_out;

    int n_assert = 0;
    int n_fail   = 0;
    int dv_count = 0;

    uart_rxd_txd #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_Serial     (rx_Serial),
        .rx_DV_out     (rx_DV_out),
        .rx_Byte_out   (rx_Byte_out),
        .tx_DV         (tx_DV),
        .tx_Byte       (tx_Byte),
        .tx_Active_out (tx_Active_out),
        .tx_Serial_out (tx_Serial_out),
        .tx_Done_out   (tx_Done_out)
    );

    always #(CLK_NS/2) clk = ~clk;

    // Counts cycles with rx_DV_out high, so one frame must add exactly one.
    always @(posedge clk) begin
        if (rx_DV_out === 1'b1) dv_count <= dv_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] b, input bit hold);
        check("tx_idle_line", {31'd0, tx_Serial_out}, 32'd1);
        tx_Byte = b;
        tx_DV   = 1'b1;
        tick();
        if (!hold) tx_DV = 1'b0;
    endtask

    // Expected frame is {stop, data, start} bits, each held CPB cycles; called on frame cycle 0.
    task automatic check_tx_frame(input logic [7:0] b, input bit corrupt);
        logic [9:0] frame;
        int errs;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            errs = 0;
            for (int c = 0; c < CPB; c++) begin
                if (tx_Serial_out !== frame[i] || tx_Active_out !== 1'b1 || tx_Done_out !== 1'b0)
                    errs++;
                if (corrupt && i == 4 && c == 0) tx_Byte = ~b;
                tick();
            end
            check($sformatf("tx_bit%0d_of_%02h", i, b), errs, 32'd0);
        end
        check("tx_done_pulse", {31'd0, tx_Done_out}, 32'd1);
        check("tx_active_fall", {31'd0, tx_Active_out}, 32'd0);
        check("tx_line_after_stop", {31'd0, tx_Serial_out}, 32'd1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input int bit_ns, input int start_extra_ns,
                            input logic stop_bit);
        int dv0;
        dv0 = dv_count;
        rx_Serial = 1'b0;
        #(bit_ns + start_extra_ns);
        for (int i = 0; i < 8; i++) begin
            rx_Serial = b[i];
            #(bit_ns);
        end
        check($sformatf("rx_byte_after_bit7_%02h", b), {24'd0, rx_Byte_out}, {24'd0, b});
        rx_Serial = stop_bit;
        #(bit_ns);
        rx_Serial = 1'b1;
        #(2 * bit_ns);
        check($sformatf("rx_dv_count_%02h", b), dv_count - dv0, {31'd0, stop_bit});
        check($sformatf("rx_byte_hold_%02h", b), {24'd0, rx_Byte_out}, {24'd0, b});
        tick();
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] b2;
        logic [7:0] prev;
        int dv0;
        int errs;
        int per;

        #5 rst_n = 1'b0;
        repeat (5) tick();
        check("rst_tx_serial", {31'd0, tx_Serial_out}, 32'd1);
        check("rst_rx_byte", {24'd0, rx_Byte_out}, 32'd0);
        check("rst_rx_dv", {31'd0, rx_DV_out}, 32'd0);
        check("rst_tx_done", {31'd0, tx_Done_out}, 32'd0);
        check("rst_tx_active", {31'd0, tx_Active_out}, 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        start_tx(8'hAB, 1'b0);
        check_tx_frame(8'hAB, 1'b0);
        tick();
        check("tx_done_once", {31'd0, tx_Done_out}, 32'd0);

        b = 8'h5C;
        start_tx(b, 1'b0);
        check_tx_frame(b, 1'b1);
        tick();
        check("tx_done_once_corrupt", {31'd0, tx_Done_out}, 32'd0);

        b  = 8'(($urandom));
        b2 = 8'(($urandom));
        start_tx(b, 1'b1);
        check_tx_frame(b, 1'b0);
        tx_Byte = b2;
        tick();
        check("b2b_gap_done", {31'd0, tx_Done_out}, 32'd0);
        check("b2b_gap_line", {31'd0, tx_Serial_out}, 32'd1);
        tick();
        check_tx_frame(b2, 1'b0);
        tx_DV = 1'b0;
        tick();
        tick();
        check("b2b_no_third_frame", {31'd0, tx_Active_out}, 32'd0);

        for (int n = 0; n < 3; n++) begin
            b = 8'($urandom);
            start_tx(b, 1'b0);
            check_tx_frame(b, 1'b0);
            tick();
        end

        rx_frame(8'h3F, 8600, 1000, 1'b1);

        for (int n = 0; n < 5; n++) begin
            b   = 8'($urandom);
            per = BIT_NS - 180 + int'($urandom_range(0, 360));
            rx_frame(b, per, 0, 1'b1);
        end

        b = ~rx_Byte_out;
        rx_frame(b, BIT_NS, 0, 1'b0);

        prev = rx_Byte_out;
        dv0  = dv_count;
        rx_Serial = 1'b0;
        repeat (50) tick();
        rx_Serial = 1'b1;
        repeat (3 * CPB) tick();
        check("glitch_byte_kept", {24'd0, rx_Byte_out}, {24'd0, prev});
        check("glitch_no_dv", dv_count - dv0, 32'd0);
        rx_frame(8'hC4, BIT_NS, 0, 1'b1);

        b  = 8'($urandom);
        b2 = 8'($urandom);
        fork
            rx_frame(b, BIT_NS, 0, 1'b1);
            begin
                start_tx(b2, 1'b0);
                check_tx_frame(b2, 1'b0);
            end
        join
        repeat (4) tick();

        start_tx(8'h00, 1'b0);
        repeat (3 * CPB) tick();
        check("midreset_active_before", {31'd0, tx_Active_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_line_high", {31'd0, tx_Serial_out}, 32'd1);
        check("midreset_active_low", {31'd0, tx_Active_out}, 32'd0);
        check("midreset_rx_byte_clr", {24'd0, rx_Byte_out}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        errs = 0;
        for (int c = 0; c < 12 * CPB; c++) begin
            if (tx_Done_out !== 1'b0 || tx_Serial_out !== 1'b1 || tx_Active_out !== 1'b0) errs++;
            tick();
        end
        check("midreset_no_done_no_activity", errs, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rxd_txd.md
# uart_rxd_txd

Full-duplex 8N1 UART engine pairing a receiver (uart_rxd) and a transmitter (uart_txd) on one system clock. It sits between the board serial pins and the challenge/response logic. It converts incoming serial frames to bytes and outgoing bytes to serial frames. The baud rate is set by a clocks-per-bit parameter; the default of 217 gives 115200 baud at 25 MHz.

## Interface
- CLKS_PER_BIT, 217, system clocks per serial bit; must be ≥ 4.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_Serial  in  1  serial input line; idles high; asynchronous to clk.
- rx_DV_out  out  1  one-cycle pulse when a complete frame with a valid stop bit has been received.
- rx_Byte_out  out  8  received byte; bit i is written when data bit i is sampled.
- tx_DV  in  1  request to send tx_Byte; sampled only while the transmitter is idle.
- tx_Byte  in  8  byte to transmit; latched when the request is accepted.
- tx_Active_out  out  1  high from frame acceptance through the end of the stop bit.
- tx_Serial_out  out  1  serial output line; idles high.
- tx_Done_out  out  1  one-cycle pulse after the stop bit completes.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Reset values: rx_DV_out=0, rx_Byte_out=0x00, tx_Active_out=0, tx_Serial_out=1, tx_Done_out=0. Both FSMs return to IDLE, and all counters clear.
- Reset mid-frame aborts the frame immediately with no partial Done or DV pulse.
- RX input: rx_Serial passes through a 2-flop synchronizer before use.
- RX FSM:
  - IDLE → START on the first synchronized low.
  - START counts to (CLKS_PER_BIT-1)/2, i.e. mid-bit, and resamples the line. If it is still low, go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA samples the line every CLKS_PER_BIT clocks into rx_Byte_out[idx], with idx going 0..7. After bit 7, go to STOP.
  - STOP samples after CLKS_PER_BIT clocks. If the line is 1, pulse rx_DV_out; if 0 (framing error), there is no pulse. Either way go to CLEANUP.
  - CLEANUP lasts 1 cycle, then IDLE.
- rx_Byte_out holds its value between frames. Its final value is complete right after the bit-7 sample, before the stop bit.
- TX FSM:
  - IDLE drives the line to 1. When tx_DV=1, latch tx_Byte, set tx_Active_out, and go to START.
  - START drives 0 for CLKS_PER_BIT clocks.
  - DATA drives bits 0..7, each for CLKS_PER_BIT clocks.
  - STOP drives 1 for CLKS_PER_BIT clocks. At its last clock, clear tx_Active_out and pulse tx_Done_out.
  - CLEANUP lasts 1 cycle, then IDLE.
- tx_DV is ignored while the transmitter is not IDLE. Changes to tx_Byte mid-frame have no effect.
- If tx_DV is held high, a new frame starts on the first IDLE cycle, producing back-to-back frames each followed by a Done pulse.
- RX and TX are fully independent; simultaneous activity on both is allowed.

## Timing
- TX: the line goes low on the cycle after tx_DV is sampled in IDLE. A frame is 10·CLKS_PER_BIT cycles of line activity, and tx_Done_out follows the stop bit. The minimum spacing between accepted requests is 10·CLKS_PER_BIT+2 cycles.
- RX: the start edge is seen 2 cycles after pin transition because of the synchronizer. Each data bit is sampled at (CLKS_PER_BIT-1)/2 + (k+1)·CLKS_PER_BIT cycles after the start detection, for k = 0..7.
- rx_DV_out rises at the stop-bit mid-sample plus 1 register cycle and lasts exactly 1 cycle.
- Bit-rate tolerance: sampling mid-bit tolerates about ±4% clock mismatch across a frame.
- Counters are sized to hold CLKS_PER_BIT-1 and wrap to 0 at each bit boundary. The bit index is 3 bits.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP, CLEANUP), used by both engines;
  - a helper constant for the half-bit count.
- Sub-modules: uart_rxd (synchronizer plus RX FSM) and uart_txd (TX FSM). The top uart_rxd_txd only instantiates and wires them.

## Test plan
- Reset: hold rst_n=0 → tx_Serial_out=1, rx_Byte_out=0x00, all pulses 0.
- TX 0xAB, CLKS_PER_BIT=217, 40 ns clk:
  - pulse tx_DV;
  - line shows 0, then bits 1,1,0,1,0,1,0,1, then 1;
  - each bit lasts 217 cycles;
  - tx_Done_out pulses once, and tx_Active_out falls on the same cycle.
- RX 0x3F driven with an 8600 ns bit period and the first data bit delayed 1000 ns → rx_Byte_out=0x3F immediately after the last data bit.
- RX with a valid stop bit → a single 1-cycle rx_DV_out. With the stop bit held low → no rx_DV_out, but rx_Byte_out is still updated.
- RX glitch: a low pulse of 50 cycles on the idle line → no state change, and rx_Byte_out is unchanged.
- Hold tx_DV high → back-to-back frames. Change tx_Byte mid-frame → it does not corrupt the current frame. Assert rst_n low mid-frame → the line returns to 1 and no tx_Done_out pulse occurs.
